// File: rtl/state_ldm_transfer_pkg.sv
// Shared types and constants for the off-chip LDM state-vector transfer block.
package state_ldm_transfer_pkg;

    // One complex amplitude: real part in the upper half, imaginary part in the lower half.
    localparam int STATE_DATA_WIDTH = 64;
    localparam int AMP_PART_WIDTH   = STATE_DATA_WIDTH / 2;

    typedef struct packed {
        logic [AMP_PART_WIDTH-1:0] re_part;
        logic [AMP_PART_WIDTH-1:0] im_part;
    } amplitude_t;

    // Transfer controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STORE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } xfer_state_t;

    // Output FIFO depth; the read credit limit equals this depth.
    localparam int OUT_FIFO_DEPTH = 2;

endpackage

// File: rtl/ldm_out_fifo.sv
// Two-entry synchronous FIFO buffering LDM read data on its way off-chip.
module ldm_out_fifo
    import state_ldm_transfer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  amplitude_t push_data_i,
    input  logic       pop_i,
    output amplitude_t pop_data_o,
    output logic [1:0] count_o,
    output logic       empty_o,
    output logic       full_o
);

    amplitude_t mem_q [OUT_FIFO_DEPTH];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    // Qualify push/pop against occupancy and compute the next count.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        do_push = push_i && (count_q != 2'd2);
        do_pop  = pop_i && (count_q != 2'd0);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointer and count registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the count alone says which entries are valid.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == 2'd0);
    assign full_o     = (count_q == 2'd2);

endmodule

// File: rtl/state_ldm_transfer.sv
// Off-chip side of the PE LDM port: loads a state vector into the PE LDMs and
// streams it back out with valid/ready backpressure.
module state_ldm_transfer
    import state_ldm_transfer_pkg::*;
#(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int LA_W             = PE_NUM_WIDTH + STATE_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_load_start,
    input  logic                                 i_store_start,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 i_in_valid,
    input  logic [STATE_DATA_WIDTH-1:0]          i_in_data,
    output logic                                 o_in_ready,
    output logic                                 o_ldm_en,
    output logic                                 o_ldm_we,
    output logic [LA_W-1:0]                      o_ldm_addr,
    output logic [STATE_DATA_WIDTH-1:0]          o_ldm_data,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_ldm_rdata,
    output logic                                 o_out_valid,
    output logic [STATE_DATA_WIDTH-1:0]          o_out_data,
    input  logic                                 i_out_ready,
    output logic                                 o_done_state_transfer,
    output logic                                 o_done_store,
    output logic                                 o_busy
);

    // Counters are one bit wider than the address so k can reach N = 2^LA_W.
    localparam int CW = LA_W + 1;
    localparam int DW = STATE_DATA_WIDTH;

    xfer_state_t               state_q;
    xfer_state_t               state_d;
    logic [CW-1:0]             k_q;
    logic [CW-1:0]             n_q;
    logic [CW-1:0]             pop_cnt_q;
    logic                      load_mode_q;
    logic                      inflight_q;
    logic [PE_NUM_WIDTH-1:0]   pe_sel_q;

    logic [MAX_QBIT_WIDTH-1:0] qbit_clamped;
    logic [CW-1:0]             n_start;
    logic                      accept_load;
    logic                      accept_store;
    logic                      load_beat;
    logic                      rd_issue;
    logic [LA_W-1:0]           rd_addr;
    logic                      pop;
    logic [2:0]                occupancy;
    logic                      credit_ok;
    logic                      last_load;
    logic                      last_issue;
    logic                      last_pop;

    amplitude_t                fifo_wdata;
    amplitude_t                fifo_rdata;
    logic [1:0]                fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;

    // Transfer length N = 2^qbit, with qbit clamped so N never exceeds the address space.
    always_comb begin
        qbit_clamped = i_qbit_num;
        if (int'(i_qbit_num) > LA_W) begin
            qbit_clamped = MAX_QBIT_WIDTH'(LA_W);
        end
        n_start = CW'(1) << qbit_clamped;
    end

    // Start acceptance, handshakes and the read-credit rule.
    always_comb begin
        accept_load  = (state_q == ST_IDLE) && i_load_start;
        accept_store = (state_q == ST_IDLE) && !i_load_start && i_store_start;
        load_beat    = (state_q == ST_LOAD) && i_in_valid;
        pop          = !fifo_empty && i_out_ready;
        // Entries that will be buffered or still arriving after this cycle's pop.
        occupancy    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        credit_ok    = (occupancy < 3'd2) && !(fifo_full && !pop);
        // The first store read goes out in the accepting cycle so data shows up
        // two cycles after the start pulse; the FIFO is always empty then.
        rd_issue     = accept_store
                       || ((state_q == ST_STORE) && (k_q < n_q) && credit_ok);
        rd_addr      = accept_store ? '0 : k_q[LA_W-1:0];
        last_load    = load_beat && (k_q == n_q - CW'(1));
        last_issue   = (state_q == ST_STORE) && rd_issue && (k_q == n_q - CW'(1));
        last_pop     = pop && (pop_cnt_q == n_q - CW'(1));
        fifo_wdata   = i_ldm_rdata[int'(pe_sel_q) * DW +: DW];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_load) begin
                    state_d = ST_LOAD;
                end else if (accept_store) begin
                    // A one-beat store has already issued its only read.
                    state_d = (n_start == CW'(1)) ? ST_DRAIN : ST_STORE;
                end
            end
            ST_LOAD:  if (last_load)  state_d = ST_DONE;
            ST_STORE: if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (last_pop)   state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Index, length, pop counters and the single in-flight read tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q         <= '0;
            n_q         <= '0;
            pop_cnt_q   <= '0;
            load_mode_q <= 1'b0;
            inflight_q  <= 1'b0;
            pe_sel_q    <= '0;
        end else begin
            inflight_q <= rd_issue;
            if (rd_issue) begin
                pe_sel_q <= rd_addr[LA_W-1 -: PE_NUM_WIDTH];
            end
            if (accept_load || accept_store) begin
                // k starts at 0; a store has already consumed index 0 on accept.
                k_q         <= accept_store ? CW'(1) : '0;
                n_q         <= n_start;
                pop_cnt_q   <= '0;
                load_mode_q <= accept_load;
            end else begin
                if (load_beat || rd_issue) k_q <= k_q + CW'(1);
                if (pop)                   pop_cnt_q <= pop_cnt_q + CW'(1);
            end
        end
    end

    ldm_out_fifo u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_wdata),
        .pop_i       (pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Output decode: LDM strobes, stream handshakes and done pulses.
    always_comb begin
        o_in_ready            = 1'b0;
        o_ldm_en              = 1'b0;
        o_ldm_we              = 1'b0;
        o_ldm_addr            = '0;
        o_ldm_data            = '0;
        o_done_state_transfer = 1'b0;
        o_done_store          = 1'b0;
        o_busy                = (state_q != ST_IDLE);
        o_out_valid           = !fifo_empty;
        o_out_data            = fifo_empty ? '0 : fifo_rdata;
        if (state_q == ST_LOAD) begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
                o_ldm_en   = 1'b1;
                o_ldm_we   = 1'b1;
                o_ldm_addr = k_q[LA_W-1:0];
                o_ldm_data = i_in_data;
            end
        end
        if (rd_issue) begin
            o_ldm_en   = 1'b1;
            o_ldm_addr = rd_addr;
        end
        if (state_q == ST_DONE) begin
            o_done_state_transfer = load_mode_q;
            o_done_store          = !load_mode_q;
        end
    end

endmodule
